pool1_rm_reader: RTL and testbench

//  Read-side controller for the pool1 simple-dual-port row-buffer RAM. On a start pulse it issues
//  NUM_WORDS sequential reads on RAM port B from a base address. It absorbs the fixed RAM read latency
//  and delivers the words as a valid/ready stream to the next layer, with full backpressure support.

---
 rtl/pool1_rm_pkg.sv | 16 +
 rtl/acc_sync_fifo.sv | 52 +++++
 rtl/pool1_rm_reader.sv | 117 +++++++++++
 tb/tb_pool1_rm_reader.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pool1_rm_pkg.sv
// Shared defaults and FSM encoding for the pool1 row-buffer read controller.
package pool1_rm_pkg;

    localparam int POOL1_ADDR_W     = 11;
    localparam int POOL1_DATA_W     = 128;
    localparam int POOL1_RD_LAT     = 2;
    localparam int POOL1_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/acc_sync_fifo.sv
// Single-clock FIFO with occupancy count; shared by the layer readers as an output skid buffer.
module acc_sync_fifo #(
    parameter int WIDTH = 129,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_pop  = pop && (count != '0);
    assign do_push = push && (count != CNTW'(DEPTH));

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= nxt(wr_ptr);
            if (do_pop)  rd_ptr <= nxt(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/pool1_rm_reader.sv
// Issues sequential RAM port-B reads for a job, absorbs read latency, and streams words out
// through a skid FIFO with full backpressure.
module pool1_rm_reader
    import pool1_rm_pkg::*;
#(
    parameter int ADDR_W     = POOL1_ADDR_W,
    parameter int DATA_W     = POOL1_DATA_W,
    parameter int RD_LAT     = POOL1_RD_LAT,
    parameter int FIFO_DEPTH = POOL1_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   num_words,
    output logic [ADDR_W-1:0] ram_addrb,
    output logic              ram_rd,
    input  logic [DATA_W-1:0] ram_doutb,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready,
    output logic              busy,
    output logic              done
);
    localparam int CNTW = $clog2(FIFO_DEPTH + 1);
    localparam int CW   = $clog2(FIFO_DEPTH + RD_LAT + 2) + 1;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   num_q, issue_cnt, acc_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [RD_LAT:0]   vld_pipe, last_pipe;
    logic [CNTW-1:0]   fifo_count;
    logic              fifo_empty;
    logic [DATA_W:0]   fifo_dout;
    logic              issue_now, last_issue, pop, credit_ok;
    logic [CW-1:0]     occ;

    assign pop = m_valid && m_ready;

    // Occupancy = every read not yet popped, net of the beat leaving this cycle;
    // counting the outgoing beat is what allows back-to-back issue with a 4-deep FIFO.
    always_comb begin
        occ = CW'(fifo_count) - CW'(pop);
        for (int i = 0; i <= RD_LAT; i++) occ = occ + CW'(vld_pipe[i]);
        credit_ok = (occ < CW'(FIFO_DEPTH));
    end

    always_comb begin
        state_d    = state_q;
        issue_now  = 1'b0;
        last_issue = 1'b0;
        case (state_q)
            IDLE:  if (start) state_d = (num_words == '0) ? DONE : ISSUE;
            ISSUE: if (credit_ok) begin
                issue_now  = 1'b1;
                last_issue = (issue_cnt + (ADDR_W+1)'(1) == num_q);
                if (last_issue) state_d = DRAIN;
            end
            DRAIN: if (fifo_empty && (vld_pipe == '0) && (acc_cnt == num_q)) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            num_q     <= '0;
            issue_cnt <= '0;
            acc_cnt   <= '0;
            addr_q    <= '0;
            ram_addrb <= '0;
            vld_pipe  <= '0;
            last_pipe <= '0;
        end else begin
            state_q   <= state_d;
            // Stage 0 is the registered read strobe; stage RD_LAT lines up with ram_doutb.
            vld_pipe  <= {vld_pipe[RD_LAT-1:0], issue_now};
            last_pipe <= {last_pipe[RD_LAT-1:0], last_issue};
            if (state_q == IDLE && start) begin
                num_q     <= num_words;
                addr_q    <= base_addr;
                issue_cnt <= '0;
                acc_cnt   <= '0;
            end
            if (issue_now) begin
                ram_addrb <= addr_q;
                addr_q    <= addr_q + ADDR_W'(1);
                issue_cnt <= issue_cnt + (ADDR_W+1)'(1);
            end
            if (pop) acc_cnt <= acc_cnt + (ADDR_W+1)'(1);
        end
    end

    acc_sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (vld_pipe[RD_LAT]),
        .din   ({last_pipe[RD_LAT], ram_doutb}),
        .pop   (pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign ram_rd  = vld_pipe[0];
    assign m_valid = !fifo_empty;
    assign m_data  = m_valid ? fifo_dout[DATA_W-1:0] : '0;
    assign m_last  = m_valid && fifo_dout[DATA_W];
    assign busy    = (state_q == ISSUE) || (state_q == DRAIN);
    assign done    = (state_q == DONE);

endmodule

// File: tb/tb_pool1_rm_reader.sv
// Bench for pool1_rm_reader: behavioural 2-cycle SDP RAM with mem[a]=a, job table plus reset sequence.
module tb_pool1_rm_reader;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [10:0]  base_addr;
    logic [11:0]  num_words;
    logic [10:0]  ram_addrb;
    logic         ram_rd;
    logic [127:0] ram_doutb;
    logic         m_valid;
    logic [127:0] m_data;
    logic         m_last;
    logic         m_ready;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    pool1_rm_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .num_words (num_words),
        .ram_addrb (ram_addrb),
        .ram_rd    (ram_rd),
        .ram_doutb (ram_doutb),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_last    (m_last),
        .m_ready   (m_ready),
        .busy      (busy),
        .done      (done)
    );

    logic [127:0] mem [2048];
    logic [127:0] ram_s1;
    initial for (int a = 0; a < 2048; a++) mem[a] = 128'(a);
    always @(posedge clk) begin
        ram_s1    <= mem[ram_addrb];
        ram_doutb <= ram_s1;
    end

    typedef struct {
        logic [127:0] d;
        logic         l;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [10:0] base;
        int          num;
        int          rmode;      // 0 always ready, 1 pattern 1,0,0,1, 2 random
        bit          restart;    // pulse start again while busy
        int          exp_first;  // -1: not checked
        int          exp_done;   // -1: not checked
    } vec_t;
    vec_t vecs[6];

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, "_ram_rd"}, 128'(ram_rd), 128'(0));
        chk({nm, "_addr"},   128'(ram_addrb), 128'(0));
        chk({nm, "_valid"},  128'(m_valid), 128'(0));
        chk({nm, "_data"},   m_data, 128'(0));
        chk({nm, "_last"},   128'(m_last), 128'(0));
        chk({nm, "_busy"},   128'(busy), 128'(0));
        chk({nm, "_done"},   128'(done), 128'(0));
    endtask

    task automatic run_job(input vec_t v);
        int c, rd_n, acc_n, dn, first_rd, first_beat, done_cyc, max_out, budget;
        logic prev_stall, prev_last;
        logic [127:0] prev_data;
        exp_t e;
        @(negedge clk);
        start     = 1'b1;
        base_addr = v.base;
        num_words = 12'(v.num);
        for (int k = 0; k < v.num; k++) begin
            e.d = 128'(11'(v.base + k));
            e.l = (k == v.num - 1);
            sb.push_back(e);
        end
        rd_n = 0; acc_n = 0; dn = 0; first_rd = -1; first_beat = -1;
        done_cyc = -1; max_out = 0; prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0;
        budget = v.num * 8 + 60;
        @(negedge clk);
        start = 1'b0;
        c = 0;
        while (c < budget) begin
            start = v.restart && (c == 2);
            if (start) begin
                base_addr = 11'd500;
                num_words = 12'd3;
            end
            case (v.rmode)
                0:       m_ready = 1'b1;
                1:       m_ready = (c % 4 == 0) || (c % 4 == 3);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            if (ram_rd) begin
                if (first_rd < 0) first_rd = c;
                chk("rd_addr", 128'(ram_addrb), 128'(11'(v.base + rd_n)));
                rd_n++;
            end
            if (rd_n - acc_n > max_out) max_out = rd_n - acc_n;
            if (prev_stall) begin
                chk("stall_valid", 128'(m_valid), 128'(1));
                chk("stall_data", m_data, prev_data);
                chk("stall_last", 128'(m_last), 128'(prev_last));
            end
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL extra_beat: got data %0h at cycle %0d, required none", m_data, c);
                end else begin
                    e = sb.pop_front();
                    chk("beat_data", m_data, e.d);
                    chk("beat_last", 128'(m_last), 128'(e.l));
                end
                if (first_beat < 0) first_beat = c;
                acc_n++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            if (c == 0 && v.num != 0) chk("busy_c0", 128'(busy), 128'(1));
            if (v.num == 0) chk("busy_zero", 128'(busy), 128'(0));
            if (done) begin
                dn++;
                if (dn == 1) done_cyc = c;
                chk("busy_at_done", 128'(busy), 128'(0));
            end
            if (dn > 0 && c >= done_cyc + 3) break;
            @(negedge clk);
            c++;
        end
        if (dn == 0) begin
            n_total++;
            $display("FAIL timeout: no done within %0d cycles (base %0d num %0d)", budget, v.base, v.num);
        end
        chk("sb_empty", 128'(sb.size()), 128'(0));
        chk("done_count", 128'(dn), 128'(1));
        chk("read_count", 128'(rd_n), 128'(v.num));
        chk("beat_count", 128'(acc_n), 128'(v.num));
        chk("max_outstanding_le4", 128'(max_out <= 4), 128'(1));
        if (v.num != 0) chk("first_rd_cycle", 128'(first_rd), 128'(1));
        if (v.exp_first >= 0) chk("first_beat_cycle", 128'(first_beat), 128'(v.exp_first));
        if (v.exp_done >= 0) chk("done_cycle", 128'(done_cyc), 128'(v.exp_done));
        sb.delete();
    endtask

    initial begin
        int c, beats;
        vecs[0] = '{base: 11'd0,    num: 8,    rmode: 0, restart: 1'b0, exp_first: 4,  exp_done: 13};
        vecs[1] = '{base: 11'd2045, num: 5,    rmode: 0, restart: 1'b0, exp_first: 4,  exp_done: 10};
        vecs[2] = '{base: 11'd10,   num: 8,    rmode: 1, restart: 1'b1, exp_first: 4,  exp_done: -1};
        vecs[3] = '{base: 11'd7,    num: 0,    rmode: 0, restart: 1'b0, exp_first: -1, exp_done: 0};
        vecs[4] = '{base: 11'd0,    num: 2048, rmode: 0, restart: 1'b0, exp_first: 4,  exp_done: 2053};
        vecs[5] = '{base: 11'd2040, num: 20,   rmode: 2, restart: 1'b0, exp_first: -1, exp_done: -1};

        rst_n = 1'b0; start = 1'b0; base_addr = '0; num_words = '0; m_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_job(vecs[i]);

        // Reset in the middle of a 16-word job, right as beat 3 is accepted.
        @(negedge clk);
        start = 1'b1; base_addr = 11'd0; num_words = 12'd16; m_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 0; beats = 0;
        while (beats < 4 && c < 100) begin
            if (m_valid && m_ready) beats++;
            if (beats < 4) begin
                @(negedge clk);
                c++;
            end
        end
        chk("pre_reset_beats", 128'(beats), 128'(4));
        rst_n = 1'b0;
        @(negedge clk);
        chk_idle_outputs("midjob_reset");
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_reset_valid", 128'(m_valid), 128'(0));
        end
        run_job('{base: 11'd100, num: 2, rmode: 0, restart: 1'b0, exp_first: 4, exp_done: 7});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
